// File: rtl/leb128_decoder_pkg.sv
// Shared cpu package: trap codes, LEB128 decoder states, sizing helper.
package leb128_decoder_pkg;

    localparam logic [3:0] TRAP_NONE         = 4'h0;
    localparam logic [3:0] TRAP_LEB_OVERFLOW = 4'h3;
    localparam logic [3:0] TRAP_LEB_NONCANON = 4'h4;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    function automatic int max_bytes(input int width);
        return (width + 6) / 7;
    endfunction

endpackage

// File: rtl/leb128_decoder_if.sv
// Fetch-to-decode LEB128 stream bundle with valid/ready on both sides.
interface leb128_decoder_if #(
    parameter int WIDTH = 64
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             signed_mode;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_len;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       trap;

    modport master (
        output in_data, in_valid, signed_mode, out_ready,
        input  in_ready, out_data, out_len, out_valid, trap
    );

    modport slave (
        input  in_data, in_valid, signed_mode, out_ready,
        output in_ready, out_data, out_len, out_valid, trap
    );
endinterface

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 immediate decoder (fetch -> decode).
// Optional: LEB128_CANONICAL_CHECK_EN traps non-minimal encodings.
module leb128_decoder
    import leb128_decoder_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MAX_BYTES = max_bytes(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    leb128_decoder_if.slave  bus
);

    localparam int REM = WIDTH - 7 * (MAX_BYTES - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [3:0]       count;
    logic             sgn;
    logic [3:0]       len_q;
    logic [3:0]       trap_q;

    logic             in_ready;
    logic             sm;
    logic [6:0]       sh;
    logic [3:0]       cnt1;
    logic [6:0]       ext_sh;
    logic [WIDTH-1:0] payload;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] ext;
    logic             last;
    logic [6:0]       hi;
    logic [6:0]       hi_exp;
    logic             bad_top;
    logic             noncanon;

    assign in_ready      = reset && (state == ST_ACC);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = acc;
    assign bus.out_len   = len_q;
    assign bus.trap      = trap_q;

    // Next accumulator value, sign-extension mask and last-byte range check
    always_comb begin
        sm      = (count == 4'd0) ? bus.signed_mode : sgn;
        sh      = 7'(count) * 7'd7;
        cnt1    = count + 4'd1;
        ext_sh  = 7'(cnt1) * 7'd7;
        payload = WIDTH'(bus.in_data[6:0]) << sh;
        acc_nx  = acc | payload;
        ext     = '0;
        if (sm && bus.in_data[6])
            ext = {WIDTH{1'b1}} << ext_sh;
        last    = (count == 4'(MAX_BYTES - 1));
        hi      = bus.in_data[6:0] >> REM;
        hi_exp  = 7'h00;
        if (sm && bus.in_data[REM-1])
            hi_exp = 7'h7F >> REM;
        bad_top = last && (hi != hi_exp);
    end

`ifdef LEB128_CANONICAL_CHECK_EN
    logic prev_b6;

    // Remember bit6 of the previous byte for the minimal-encoding check
    always_ff @(posedge clk) begin
        if (!reset)
            prev_b6 <= 1'b0;
        else if (bus.in_valid && in_ready)
            prev_b6 <= bus.in_data[6];
    end

    // A redundant trailing byte only repeats what the previous byte implied
    always_comb begin
        noncanon = 1'b0;
        if (count != 4'd0) begin
            if (sm)
                noncanon = (bus.in_data == 8'h00 && !prev_b6) ||
                           (bus.in_data == 8'h7F && prev_b6);
            else
                noncanon = (bus.in_data == 8'h00);
        end
    end
`else
    assign noncanon = 1'b0;
`endif

    // Accumulate / present / trap state machine
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_ACC;
            acc    <= '0;
            count  <= 4'd0;
            sgn    <= 1'b0;
            len_q  <= 4'd0;
            trap_q <= TRAP_NONE;
        end else begin
            case (state)
                ST_ACC: begin
                    if (bus.in_valid && in_ready) begin
                        if (count == 4'd0)
                            sgn <= bus.signed_mode;
                        if (bus.in_data[7]) begin
                            if (last) begin
                                state  <= ST_ERROR;
                                trap_q <= TRAP_LEB_OVERFLOW;
                            end else begin
                                acc   <= acc_nx;
                                count <= cnt1;
                            end
                        end else if (noncanon) begin
                            state  <= ST_ERROR;
                            trap_q <= TRAP_LEB_NONCANON;
                        end else if (bad_top) begin
                            state  <= ST_ERROR;
                            trap_q <= TRAP_LEB_OVERFLOW;
                        end else begin
                            acc   <= acc_nx | ext;
                            count <= cnt1;
                            len_q <= cnt1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_ACC;
                        acc   <= '0;
                        count <= 4'd0;
                    end
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed self-checking bench for leb128_decoder (WIDTH=64).
// Honors LEB128_CANONICAL_CHECK_EN when the build defines it.
module tb_leb128_decoder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    leb128_decoder_if #(.WIDTH(64)) bus ();

    leb128_decoder #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic sm);
        int n;
        n = 0;
        bus.in_data     = b;
        bus.signed_mode = sm;
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20)
            check("send_timeout", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] d,
                              input logic [3:0] len);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, bus.out_data, d);
        check({tag, "_len"}, 64'(bus.out_len), 64'(len));
        check({tag, "_trap"}, 64'(bus.trap), 64'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_valid    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b0;

        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_len", 64'(bus.out_len), 64'd0);
        check("rst_trap", 64'(bus.trap), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        send(8'hE5, 1'b0);
        send(8'h8E, 1'b0);
        check("u3_not_early", 64'(bus.out_valid), 64'd0);
        send(8'h26, 1'b0);
        check("u3_latency", 64'(bus.out_valid), 64'd1);
        check("u3_busy", 64'(bus.in_ready), 64'd0);
        expect_out("u3", 64'd624485, 4'd3);
        check("u3_ready_again", 64'(bus.in_ready), 64'd1);
        check("u3_valid_drop", 64'(bus.out_valid), 64'd0);

        send(8'hC0, 1'b1);
        send(8'hBB, 1'b1);
        send(8'h78, 1'b1);
        expect_out("s3", 64'hFFFF_FFFF_FFFE_1DC0, 4'd3);

        send(8'h7F, 1'b1);
        expect_out("s7f", 64'hFFFF_FFFF_FFFF_FFFF, 4'd1);
        send(8'h7F, 1'b0);
        expect_out("u7f", 64'd127, 4'd1);

        send(8'h05, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", bus.out_data, 64'd5);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            step();
        end
        expect_out("bp", 64'd5, 4'd1);
        check("bp_release", 64'(bus.in_ready), 64'd1);
        send(8'h01, 1'b0);
        expect_out("bp_next", 64'd1, 4'd1);

        for (int i = 0; i < 9; i++)
            send(8'hFF, 1'b0);
        send(8'h01, 1'b0);
        expect_out("umax", 64'hFFFF_FFFF_FFFF_FFFF, 4'd10);

        for (int i = 0; i < 10; i++)
            send(8'h80, 1'b0);
        check("ovf_trap", 64'(bus.trap), 64'd3);
        for (int i = 0; i < 20; i++) begin
            check("ovf_in_ready", 64'(bus.in_ready), 64'd0);
            check("ovf_out_valid", 64'(bus.out_valid), 64'd0);
            check("ovf_sticky", 64'(bus.trap), 64'd3);
            step();
        end
        reset = 1'b0;
        step();
        check("ovf_rst_trap", 64'(bus.trap), 64'd0);
        reset = 1'b1;
        #1;
        check("ovf_rst_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 9; i++)
            send(8'hFF, 1'b0);
        send(8'h02, 1'b0);
        check("top_trap", 64'(bus.trap), 64'd3);
        check("top_valid", 64'(bus.out_valid), 64'd0);
        do_reset();

        send(8'h81, 1'b0);
        send(8'h82, 1'b0);
        do_reset();
        send(8'h05, 1'b0);
        expect_out("midrst", 64'd5, 4'd1);

        send(8'h80, 1'b0);
        send(8'h00, 1'b0);
`ifdef LEB128_CANONICAL_CHECK_EN
        check("nc_trap", 64'(bus.trap), 64'd4);
        check("nc_valid", 64'(bus.out_valid), 64'd0);
        do_reset();
`else
        expect_out("nc", 64'd0, 4'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Byte-serial LEB128 immediate decoder between the ROM fetch stream and the cpu decode stage.
- Accepts one bytecode byte per cycle and assembles an unsigned or signed LEB128 value.
- Presents the sign/zero-extended WIDTH-bit result and its encoded length to decode with a valid/ready handshake.
- Raises a trap code on malformed encodings.

Parameters:
- WIDTH, 64, decoded value width; legal values are 32 and 64.
- MAX_BYTES, (WIDTH+6)/7, maximum encoded length: 10 for WIDTH=64, 5 for WIDTH=32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_data  in  8  bytecode byte from fetch
- in_valid  in  1  in_data valid
- in_ready  out  1  decoder accepts in_data this cycle
- signed_mode  in  1  1 = SLEB128; sampled with the first byte of each value
- out_data  out  WIDTH  decoded value
- out_len  out  4  number of bytes consumed, 1..MAX_BYTES
- out_valid  out  1  out_data/out_len valid
- out_ready  in  1  decode stage consumes the result
- trap  out  4  0 = none, else trap code

Behaviour:
- Reset values (reset low at a clk edge): state=ACC, acc=0, count=0, in_ready=0 during reset, out_valid=0, out_data=0, out_len=0, trap=0. in_ready=1 from the first cycle after reset returns high.
- Reset mid-value discards all partial state.
- State ACC:
  - in_ready=1.
  - Byte accepted when in_valid&in_ready.
  - acc |= (in_data[6:0] << 7*count); count++.
  - First byte latches signed_mode.
- Continuation (in_data[7]=1) with count<MAX_BYTES-1: stay in ACC.
- Continuation on byte number MAX_BYTES: go to ERROR with trap=TRAP_LEB_OVERFLOW.
- Final byte (in_data[7]=0): go to DONE.
  - Signed values with in_data[6]=1 and 7*count<WIDTH have bits [WIDTH-1:7*count] set to 1. Otherwise upper bits are 0.
  - out_len=count.
- Final byte MAX_BYTES: only the low WIDTH-7*(MAX_BYTES-1) payload bits are meaningful.
  - Unsigned: the remaining payload bits must be 0.
  - Signed: the remaining payload bits must equal the top meaningful bit.
  - Violation: go to ERROR with trap=TRAP_LEB_OVERFLOW.
- DONE:
  - out_valid=1 on the cycle after the final byte is accepted (latency 1).
  - in_ready=0.
  - out_data and out_len are held stable until out_ready.
  - On out_valid&out_ready: next cycle is ACC, acc=0, count=0, out_valid=0, in_ready=1.
  - Throughput: N bytes take N+1 cycles minimum.
- ERROR is sticky until reset: in_ready=0, out_valid=0, trap held.
- in_valid while in_ready=0: the byte is not consumed; the upstream stage must hold it.

Optional Feature:
- Macro: LEB128_CANONICAL_CHECK_EN.
- Defined: non-minimal encodings go to ERROR with trap=TRAP_LEB_NONCANON. Cases:
  - Unsigned: last byte 0x00 with count>1.
  - Signed: last byte 0x00 and previous byte bit6=0.
  - Signed: last byte 0x7F and previous byte bit6=1.
  - The previous byte's bit6 is registered for this check.
- Not defined: non-minimal encodings decode normally; no extra register is present.

Decomposition:
- Shared cpu package holds:
  - 4-bit trap codes: TRAP_NONE=4'h0, TRAP_LEB_OVERFLOW=4'h3, TRAP_LEB_NONCANON=4'h4.
  - The state enum: ACC, DONE, ERROR.
  - A function computing MAX_BYTES from WIDTH.
- Single module; no sub-module. Sign extension is an inline mask computed from count.

Test Plan:
- Unsigned E5,8E,26 back-to-back → out_data=624485, out_len=3; out_valid rises the cycle after the 3rd byte; trap=0.
- Signed C0,BB,78 → out_data=64'hFFFF_FFFF_FFFE_1DC0 (-123456), out_len=3.
- Single byte 7F:
  - Signed → all ones, out_len=1.
  - Unsigned → 127.
- Backpressure:
  - Decode 05 with out_ready low for 5 cycles → out_data=5 held stable, in_ready=0.
  - Raise out_ready → in_ready=1 next cycle.
  - Then 01 → out_data=1.
- Overflow (WIDTH=64): ten bytes of 0x80 → trap=3 after the 10th byte is accepted, in_ready=0, out_valid=0 for 20 cycles. Reset low for one edge → trap=0, in_ready=1.
- Reset after 2 continuation bytes, then byte 05 → out_data=5, out_len=1.
- With LEB128_CANONICAL_CHECK_EN:
  - Unsigned 80,00 → trap=4.
  - Without the macro → out_data=0, out_len=2.
